// File: rtl/alu_share_ctrl_pkg.sv
// Shared opcode constants and sequencer state encoding for the shared-ALU controller.
package alu_pkg;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY_WAIT = 2'd1,
        DONE      = 2'd2
    } state_t;

    // Opcodes with bit 2 set are reserved and never reach the ALU.
    function automatic logic op_reserved(input logic [2:0] sel);
        return sel[2];
    endfunction

endpackage

// File: rtl/alu_share_ctrl_arb.sv
// Two-way round-robin picker: on contention the requester that did not win last time is chosen.
module rr_arb2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic valid_o,
    output logic winner_o
);

    always_comb begin
        valid_o  = req0_i | req1_i;
        winner_o = 1'b0;
        if (req0_i && req1_i) begin
            winner_o = ~last_grant_i;
        end else if (req1_i) begin
            winner_o = 1'b1;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two requesters: latch winner's operands, hold them for the
// settle time, capture the result and return it with a one-cycle ACK.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQ0,
    input  logic [WIDTH-1:0] DATA1_0,
    input  logic [WIDTH-1:0] DATA2_0,
    input  logic [2:0]       SELECT_0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] DATA1_1,
    input  logic [WIDTH-1:0] DATA2_1,
    input  logic [2:0]       SELECT_1,
    output logic             ACK0,
    output logic             ACK1,
    output logic [WIDTH-1:0] RESULT0,
    output logic [WIDTH-1:0] RESULT1,
    output logic             ZERO0,
    output logic             ZERO1,
    output logic             ERR,
    output logic             BUSY,
    output logic [WIDTH-1:0] ALU_DATA1,
    output logic [WIDTH-1:0] ALU_DATA2,
    output logic [2:0]       ALU_SELECT,
    input  logic [WIDTH-1:0] ALU_RESULT,
    input  logic             ALU_ZERO
);

    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             win_q;
    logic             last_grant_q;
    logic             ack0_q, ack1_q, err_q, busy_q;
    logic [WIDTH-1:0] res0_q, res1_q;
    logic             zero0_q, zero1_q;
    logic [WIDTH-1:0] alu_d1_q, alu_d2_q;
    logic [2:0]       alu_sel_q;

    logic             grant_valid;
    logic             grant_idx;
    logic [WIDTH-1:0] d1_d, d2_d;
    logic [2:0]       sel_d;

    rr_arb2 u_arb (
        .req0_i       (REQ0),
        .req1_i       (REQ1),
        .last_grant_i (last_grant_q),
        .valid_o      (grant_valid),
        .winner_o     (grant_idx)
    );

    always_comb begin
        d1_d  = DATA1_0;
        d2_d  = DATA2_0;
        sel_d = SELECT_0;
        if (grant_idx) begin
            d1_d  = DATA1_1;
            d2_d  = DATA2_1;
            sel_d = SELECT_1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            win_q        <= 1'b0;
            last_grant_q <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            res0_q       <= '0;
            res1_q       <= '0;
            zero0_q      <= 1'b0;
            zero1_q      <= 1'b0;
            alu_d1_q     <= '0;
            alu_d2_q     <= '0;
            alu_sel_q    <= '0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        win_q    <= grant_idx;
                        alu_d1_q <= d1_d;
                        alu_d2_q <= d2_d;
                        busy_q   <= 1'b1;
                        // Reserved ops skip the ALU entirely and complete on the next cycle.
                        if (op_reserved(sel_d)) begin
                            err_q   <= 1'b1;
                            ack0_q  <= ~grant_idx;
                            ack1_q  <= grant_idx;
                            state_q <= DONE;
                        end else begin
                            alu_sel_q <= sel_d;
                            cnt_q     <= CW'(WAIT_CYCLES);
                            state_q   <= BUSY_WAIT;
                        end
                    end
                end
                BUSY_WAIT: begin
                    if (cnt_q == CW'(1)) begin
                        if (win_q) begin
                            res1_q  <= ALU_RESULT;
                            zero1_q <= ALU_ZERO;
                            ack1_q  <= 1'b1;
                        end else begin
                            res0_q  <= ALU_RESULT;
                            zero0_q <= ALU_ZERO;
                            ack0_q  <= 1'b1;
                        end
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    last_grant_q <= win_q;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ACK0       = ack0_q;
    assign ACK1       = ack1_q;
    assign ERR        = err_q;
    assign BUSY       = busy_q;
    assign RESULT0    = res0_q;
    assign RESULT1    = res1_q;
    assign ZERO0      = zero0_q;
    assign ZERO1      = zero1_q;
    assign ALU_DATA1  = alu_d1_q;
    assign ALU_DATA2  = alu_d2_q;
    assign ALU_SELECT = alu_sel_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: transaction-level arbitration/latency model
// plus a behavioural ALU, driven by directed and randomized requester traffic.
`timescale 1ns/1ps
module tb_alu_share_ctrl;

    localparam int WIDTH = 8;
    localparam int WAIT  = 1;

    logic       CLK;
    logic       RESET;
    logic       REQ0, REQ1;
    logic [7:0] DATA1_0, DATA2_0, DATA1_1, DATA2_1;
    logic [2:0] SELECT_0, SELECT_1;
    logic       ACK0, ACK1, ZERO0, ZERO1, ERR, BUSY;
    logic [7:0] RESULT0, RESULT1, ALU_DATA1, ALU_DATA2;
    logic [2:0] ALU_SELECT;
    logic [7:0] ALU_RESULT;
    logic       ALU_ZERO;

    int n_checks = 0;
    int n_fail   = 0;

    alu_share_ctrl #(.WIDTH(WIDTH), .WAIT_CYCLES(WAIT)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0(REQ0), .DATA1_0(DATA1_0), .DATA2_0(DATA2_0), .SELECT_0(SELECT_0),
        .REQ1(REQ1), .DATA1_1(DATA1_1), .DATA2_1(DATA2_1), .SELECT_1(SELECT_1),
        .ACK0(ACK0), .ACK1(ACK1), .RESULT0(RESULT0), .RESULT1(RESULT1),
        .ZERO0(ZERO0), .ZERO1(ZERO1), .ERR(ERR), .BUSY(BUSY),
        .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2), .ALU_SELECT(ALU_SELECT),
        .ALU_RESULT(ALU_RESULT), .ALU_ZERO(ALU_ZERO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural ALU attached to the shared port
    always_comb begin
        case (ALU_SELECT)
            3'b000:  ALU_RESULT = ALU_DATA1;
            3'b001:  ALU_RESULT = ALU_DATA1 + ALU_DATA2;
            3'b010:  ALU_RESULT = ALU_DATA1 & ALU_DATA2;
            3'b011:  ALU_RESULT = ALU_DATA1 | ALU_DATA2;
            default: ALU_RESULT = 8'h00;
        endcase
    end
    assign ALU_ZERO = (ALU_RESULT == 8'h00);

    function automatic int ref_result(input int sel, input int a, input int b);
        case (sel)
            0:       return a;
            1:       return (a + b) % 256;
            2:       return a & b;
            3:       return a | b;
            default: return 0;
        endcase
    endfunction

    // scramble: 0 keep operands, 1 zero them after grant, 2 randomize them after grant
    typedef struct {
        int sel;
        int a;
        int b;
        int gap;
        int scramble;
        bit drop;
    } op_t;

    op_t q0[$];
    op_t q1[$];

    int lg_m;
    int res_m[2];
    bit zero_m[2];
    int alu_sel_m, alu_d1_m, alu_d2_m;
    bit alu_d_known;

    function automatic op_t mk_op(input int sel, input int a, input int b,
                                  input int gap, input int scramble, input bit drop);
        op_t o;
        o.sel = sel; o.a = a; o.b = b; o.gap = gap; o.scramble = scramble; o.drop = drop;
        return o;
    endfunction

    task automatic model_reset;
        lg_m = 1;
        res_m[0] = 0; res_m[1] = 0;
        zero_m[0] = 1'b0; zero_m[1] = 1'b0;
        alu_sel_m = 0; alu_d1_m = 0; alu_d2_m = 0;
        alu_d_known = 1'b1;
    endtask

    task automatic drive(input int i, input bit rq, input int a, input int b, input int s);
        if (i == 0) begin
            REQ0 = rq; DATA1_0 = 8'(a); DATA2_0 = 8'(b); SELECT_0 = 3'(s);
        end else begin
            REQ1 = rq; DATA1_1 = 8'(a); DATA2_1 = 8'(b); SELECT_1 = 3'(s);
        end
    endtask

    // Plays queued ops from both requesters; the model predicts grant order,
    // ACK/ERR/BUSY timing, results and ALU operand registers edge by edge.
    task automatic run_traffic(input int budget);
        op_t        cur[2];
        bit         have[2];
        int         wait_c[2];
        bit         gnt[2];
        bit         inflight, done_now;
        int         win, ack_edge, free_edge, k, r;
        op_t        wop;
        logic [3:0] exp_hs;
        logic [17:0] exp_res;
        inflight = 1'b0; free_edge = 0; win = 0; ack_edge = 0; k = 0;
        wop = mk_op(0, 0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            have[i] = 1'b0; gnt[i] = 1'b0; wait_c[i] = 0;
            cur[i] = mk_op(0, 0, 0, 0, 0, 1'b0);
        end
        if (q0.size() > 0) begin cur[0] = q0.pop_front(); have[0] = 1'b1; wait_c[0] = cur[0].gap; end
        if (q1.size() > 0) begin cur[1] = q1.pop_front(); have[1] = 1'b1; wait_c[1] = cur[1].gap; end

        while ((have[0] || have[1] || inflight) && k < budget) begin
            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                bit rq;
                int a, b, s;
                rq = have[i] && (wait_c[i] == 0) && !(gnt[i] && cur[i].drop);
                a = cur[i].a; b = cur[i].b; s = cur[i].sel;
                if (gnt[i] && cur[i].scramble == 1) begin
                    a = 0; b = 0; s = $urandom_range(0, 7);
                end else if (gnt[i] && cur[i].scramble == 2) begin
                    a = $urandom_range(0, 255); b = $urandom_range(0, 255); s = $urandom_range(0, 7);
                end
                drive(i, rq, a, b, s);
            end
            @(posedge CLK);
            r = {30'd0, REQ1, REQ0};
            if (!inflight && k >= free_edge && r != 0) begin
                win = (r == 3) ? 1 - lg_m : ((r == 2) ? 1 : 0);
                wop = cur[win];
                gnt[win] = 1'b1;
                inflight = 1'b1;
                ack_edge = k + ((wop.sel >= 4) ? 0 : WAIT);
                if (wop.sel < 4) begin
                    alu_sel_m = wop.sel; alu_d1_m = wop.a; alu_d2_m = wop.b; alu_d_known = 1'b1;
                end else begin
                    alu_d_known = 1'b0;
                end
            end
            done_now = inflight && (k == ack_edge);
            if (done_now) begin
                if (wop.sel < 4) begin
                    res_m[win]  = ref_result(wop.sel, wop.a, wop.b);
                    zero_m[win] = (res_m[win] == 0);
                end
                lg_m = win;
            end
            #1;
            exp_hs = {done_now && win == 0, done_now && win == 1, done_now && wop.sel >= 4, inflight};
            n_checks++;
            if ({ACK0, ACK1, ERR, BUSY} !== exp_hs) begin
                n_fail++;
                $display("FAIL handshake edge %0d: {ACK0,ACK1,ERR,BUSY} got %b expected %b", k, {ACK0, ACK1, ERR, BUSY}, exp_hs);
            end
            exp_res = {8'(res_m[0]), zero_m[0], 8'(res_m[1]), zero_m[1]};
            n_checks++;
            if ({RESULT0, ZERO0, RESULT1, ZERO1} !== exp_res) begin
                n_fail++;
                $display("FAIL results edge %0d: R0=%h Z0=%b R1=%h Z1=%b expected R0=%h Z0=%b R1=%h Z1=%b", k,
                         RESULT0, ZERO0, RESULT1, ZERO1, exp_res[17:10], exp_res[9], exp_res[8:1], exp_res[0]);
            end
            n_checks++;
            if (ALU_SELECT !== 3'(alu_sel_m)) begin
                n_fail++;
                $display("FAIL alu_select edge %0d: got %b expected %b", k, ALU_SELECT, 3'(alu_sel_m));
            end
            if (alu_d_known) begin
                n_checks++;
                if ({ALU_DATA1, ALU_DATA2} !== {8'(alu_d1_m), 8'(alu_d2_m)}) begin
                    n_fail++;
                    $display("FAIL alu_data edge %0d: got %h/%h expected %h/%h", k, ALU_DATA1, ALU_DATA2,
                             8'(alu_d1_m), 8'(alu_d2_m));
                end
            end
            for (int i = 0; i < 2; i++)
                if (have[i] && wait_c[i] > 0) wait_c[i]--;
            if (done_now) begin
                inflight  = 1'b0;
                free_edge = k + 2;
                gnt[win]  = 1'b0;
                have[win] = 1'b0;
                if (win == 0 && q0.size() > 0) begin
                    cur[0] = q0.pop_front(); have[0] = 1'b1; wait_c[0] = cur[0].gap;
                end else if (win == 1 && q1.size() > 0) begin
                    cur[1] = q1.pop_front(); have[1] = 1'b1; wait_c[1] = cur[1].gap;
                end
            end
            k++;
        end
        n_checks++;
        if (have[0] || have[1] || inflight) begin
            n_fail++;
            $display("FAIL traffic_timeout: ops still pending after %0d cycles, expected none", budget);
        end
        q0.delete();
        q1.delete();
        // One idle cycle so the next scenario starts from IDLE
        @(negedge CLK);
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        @(posedge CLK);
        #1;
        n_checks++;
        if ({ACK0, ACK1, BUSY} !== 3'b000) begin
            n_fail++;
            $display("FAIL settle_idle: {ACK0,ACK1,BUSY} got %b expected 000", {ACK0, ACK1, BUSY});
        end
    endtask

    task automatic test_reset;
        @(negedge CLK);
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if ({ACK0, ACK1, ERR, BUSY, RESULT0, RESULT1, ZERO0, ZERO1, ALU_DATA1, ALU_DATA2, ALU_SELECT} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: ACK0=%b ACK1=%b ERR=%b BUSY=%b R0=%h R1=%h Z0=%b Z1=%b AD1=%h AD2=%h AS=%b, expected all zero",
                     ACK0, ACK1, ERR, BUSY, RESULT0, RESULT1, ZERO0, ZERO1, ALU_DATA1, ALU_DATA2, ALU_SELECT);
        end
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic test_single;
        q0.push_back(mk_op(int'(alu_pkg::OP_ADD), 5, 3, 0, 0, 1'b0));
        run_traffic(20);
        n_checks++;
        if ({RESULT0, ZERO0} !== {8'd8, 1'b0}) begin
            n_fail++;
            $display("FAIL single_add: RESULT0=%h ZERO0=%b expected 08/0", RESULT0, ZERO0);
        end
    endtask

    task automatic test_tie;
        test_reset();
        q0.push_back(mk_op(int'(alu_pkg::OP_AND), 8'hF0, 8'h0F, 0, 0, 1'b0));
        q1.push_back(mk_op(int'(alu_pkg::OP_OR),  8'hF0, 8'h0F, 0, 0, 1'b0));
        run_traffic(30);
        n_checks++;
        if ({RESULT0, ZERO0, RESULT1, ZERO1} !== {8'h00, 1'b1, 8'hFF, 1'b0}) begin
            n_fail++;
            $display("FAIL tie_results: R0=%h Z0=%b R1=%h Z1=%b expected 00/1 FF/0", RESULT0, ZERO0, RESULT1, ZERO1);
        end
    endtask

    task automatic test_contention;
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk_op($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255), 0, 0, 1'b0));
            q1.push_back(mk_op($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255), 0, 0, 1'b0));
        end
        run_traffic(40);
    endtask

    task automatic test_wrap_hold;
        q1.push_back(mk_op(int'(alu_pkg::OP_ADD), 127, 1, 0, 1, 1'b0));
        q0.push_back(mk_op(int'(alu_pkg::OP_OR), 8'h12, 8'h40, 4, 2, 1'b0));
        run_traffic(30);
        n_checks++;
        if (RESULT1 !== 8'h80) begin
            n_fail++;
            $display("FAIL wrap_hold: RESULT1=%h expected 80", RESULT1);
        end
    endtask

    task automatic test_reserved;
        q0.push_back(mk_op(int'(alu_pkg::OP_OR), 8'h21, 8'h04, 0, 0, 1'b0));
        q0.push_back(mk_op(5, $urandom_range(0, 255), $urandom_range(0, 255), 0, 0, 1'b0));
        run_traffic(30);
        n_checks++;
        if ({RESULT0, ALU_SELECT} !== {8'h25, 3'b011}) begin
            n_fail++;
            $display("FAIL reserved_hold: RESULT0=%h ALU_SELECT=%b expected 25/011", RESULT0, ALU_SELECT);
        end
    endtask

    task automatic test_reset_midop;
        q0.push_back(mk_op(int'(alu_pkg::OP_FWD), 8'h11, 0, 0, 0, 1'b0));
        run_traffic(20);
        @(negedge CLK);
        drive(1, 1'b1, 20, 22, int'(alu_pkg::OP_ADD));
        @(posedge CLK);
        #1;
        n_checks++;
        if ({BUSY, ACK1} !== 2'b10) begin
            n_fail++;
            $display("FAIL midop_grant: {BUSY,ACK1} got %b expected 10", {BUSY, ACK1});
        end
        @(negedge CLK);
        RESET = 1'b1;
        drive(1, 1'b0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK);
            #1;
            n_checks++;
            if ({ACK0, ACK1, ERR, BUSY, RESULT0, RESULT1, ZERO0, ZERO1, ALU_DATA1, ALU_DATA2, ALU_SELECT} !== '0) begin
                n_fail++;
                $display("FAIL midop_reset cycle %0d: ACK1=%b ERR=%b BUSY=%b R0=%h R1=%h AD1=%h AD2=%h AS=%b, expected all zero",
                         i, ACK1, ERR, BUSY, RESULT0, RESULT1, ALU_DATA1, ALU_DATA2, ALU_SELECT);
            end
            @(negedge CLK);
            RESET = 1'b0;
        end
        model_reset();
        // Tie straight after reset: requester 0 must win again
        q0.push_back(mk_op(int'(alu_pkg::OP_ADD), 1, 2, 0, 0, 1'b0));
        q1.push_back(mk_op(int'(alu_pkg::OP_ADD), 3, 4, 0, 0, 1'b0));
        run_traffic(30);
        q1.push_back(mk_op(int'(alu_pkg::OP_ADD), 20, 22, 0, 0, 1'b0));
        run_traffic(20);
        n_checks++;
        if (RESULT1 !== 8'd42) begin
            n_fail++;
            $display("FAIL post_reset_req1: RESULT1=%h expected 2a", RESULT1);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 10; i++) begin
            int s0, s1;
            s0 = ($urandom_range(0, 9) > 7) ? $urandom_range(4, 7) : $urandom_range(0, 3);
            s1 = ($urandom_range(0, 9) > 7) ? $urandom_range(4, 7) : $urandom_range(0, 3);
            q0.push_back(mk_op(s0, $urandom_range(0, 255), $urandom_range(0, 255),
                               $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1))));
            q1.push_back(mk_op(s1, $urandom_range(0, 255), $urandom_range(0, 255),
                               $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1))));
        end
        run_traffic(400);
    endtask

    initial begin
        RESET = 1'b1;
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        model_reset();
        test_reset();
        test_single();
        test_tie();
        test_contention();
        test_wrap_hold();
        test_reserved();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
